pid_ctrl_param: RTL and testbench

PID_CTRL_PARAM -- requirements
Module: pid_ctrl_param

---
 rtl/pid_pkg.sv | 23 ++
 rtl/pid_deriv_hist.sv | 54 +++++
 rtl/pid_ctrl_param.sv | 176 +++++++++++++++++
 tb/tb_pid_ctrl_param.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/pid_pkg.sv
// Shared types and constants for the PID drive controller.
// PID_FAST_SIM_EN shortens the decimation tick from 2^20 to 2^14 clocks.
package pid_pkg;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_WARMUP = 2'd1,
    S_RUN    = 2'd2
  } pid_state_e;

  localparam int        DIFF_W   = 9;
  localparam int signed DIFF_MAX = 255;
  localparam int signed DIFF_MIN = -256;

  localparam int DEC_W = 20;

`ifdef PID_FAST_SIM_EN
  localparam int TICK_BITS = 14;
`else
  localparam int TICK_BITS = DEC_W;
`endif

endpackage

// File: rtl/pid_deriv_hist.sv
// Derivative path: error history shift register, difference against the oldest
// entry, saturation to 9 signed bits and a KD_SHIFT gain.
module pid_deriv_hist
  import pid_pkg::*;
#(
  parameter int ERR_W    = 13,
  parameter int D_DEPTH  = 3,
  parameter int KD_SHIFT = 1
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             clr_i,
  input  logic                             shift_i,
  input  logic signed [ERR_W-1:0]          err_i,
  output logic signed [DIFF_W+KD_SHIFT-1:0] d_o
);

  localparam int D_W = DIFF_W + KD_SHIFT;

  logic signed [ERR_W-1:0]  hist_q [D_DEPTH];
  logic signed [ERR_W:0]    diff;
  logic signed [DIFF_W-1:0] diff_sat;
  logic signed [D_W-1:0]    d_q;

  always_comb begin
    diff = (ERR_W+1)'(err_i) - (ERR_W+1)'(hist_q[D_DEPTH-1]);
    if (diff > DIFF_MAX) begin
      diff_sat = DIFF_W'(DIFF_MAX);
    end else if (diff < DIFF_MIN) begin
      diff_sat = DIFF_W'(DIFF_MIN);
    end else begin
      diff_sat = diff[DIFF_W-1:0];
    end
  end

  // NOTE: the history is an explicitly reset register array, not a RAM, because
  // it must read back as zero after reset and after every idle cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < D_DEPTH; k++) hist_q[k] <= '0;
      d_q <= '0;
    end else if (clr_i) begin
      for (int k = 0; k < D_DEPTH; k++) hist_q[k] <= '0;
      d_q <= '0;
    end else if (shift_i) begin
      hist_q[0] <= err_i;
      for (int k = 1; k < D_DEPTH; k++) hist_q[k] <= hist_q[k-1];
      d_q <= D_W'(diff_sat) <<< KD_SHIFT;
    end
  end

  assign d_o = d_q;

endmodule

// File: rtl/pid_ctrl_param.sv
// PID drive controller: decimated integrator/derivative, idle clear, warm-up gating,
// clamped drive output. Tick period set by PID_FAST_SIM_EN (via pid_pkg) or TICK_W.
module pid_ctrl_param
  import pid_pkg::*;
#(
  parameter int ERR_W    = 13,
  parameter int OUT_W    = 12,
  parameter int INT_W    = 18,
  parameter int D_DEPTH  = 3,
  parameter int KD_SHIFT = 1,
  parameter int TICK_W   = TICK_BITS
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic signed [ERR_W-1:0] error,
  input  logic                    err_vld,
  input  logic                    not_pedaling,
  output logic        [OUT_W-1:0] drv_mag,
  output logic                    drv_vld,
  output logic                    sat_hi
);

  localparam int               SUM_W     = OUT_W + 2;
  localparam int               D_W       = DIFF_W + KD_SHIFT;
  localparam logic [DEC_W-1:0] TICK_MASK = {DEC_W{1'b1}} >> (DEC_W - TICK_W);
  localparam logic [INT_W-1:0] INT_MAX   = {1'b0, {(INT_W-1){1'b1}}};

  logic [DEC_W-1:0] dec_q;
  logic             tick;

  // NOTE: all sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of process ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) dec_q <= '0;
    else        dec_q <= dec_q + 1'b1;
  end

  // Bits above the tick window are forced high so only the low TICK_W bits matter.
  assign tick = &(dec_q | ~TICK_MASK);

  pid_state_e state_q, state_d;
  logic [2:0] warm_q, warm_d;

  // NOTE: every output of this block gets a default first, so no path infers a latch.
  always_comb begin
    state_d = state_q;
    warm_d  = warm_q;
    if (not_pedaling) begin
      state_d = S_IDLE;
      warm_d  = '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          state_d = S_WARMUP;
          warm_d  = '0;
        end
        S_WARMUP: begin
          if (tick) begin
            if (warm_q == 3'(D_DEPTH - 1)) state_d = S_RUN;
            else                           warm_d  = warm_q + 1'b1;
          end
        end
        S_RUN:   state_d = S_RUN;
        default: state_d = S_IDLE;
      endcase
    end
  end

  logic clr, upd;
  assign clr = not_pedaling || (state_q == S_IDLE);
  assign upd = tick && err_vld && !clr;

  logic        [INT_W-1:0] integ_q, integ_d;
  logic signed [INT_W:0]   integ_sum;

  always_comb begin
    integ_sum = $signed({1'b0, integ_q}) + (INT_W+1)'(error);
    integ_d   = integ_q;
    if (clr) begin
      integ_d = '0;
    end else if (upd) begin
      if (integ_sum[INT_W])        integ_d = '0;
      else if (integ_sum[INT_W-1]) integ_d = INT_MAX;
      else                         integ_d = integ_sum[INT_W-1:0];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      warm_q  <= '0;
      integ_q <= '0;
    end else begin
      state_q <= state_d;
      warm_q  <= warm_d;
      integ_q <= integ_d;
    end
  end

  logic signed [D_W-1:0] d_term;

  pid_deriv_hist #(
    .ERR_W   (ERR_W),
    .D_DEPTH (D_DEPTH),
    .KD_SHIFT(KD_SHIFT)
  ) u_deriv (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr_i  (clr),
    .shift_i(upd),
    .err_i  (error),
    .d_o    (d_term)
  );

  // Stage 1 holds the sampled error; d_term is enabled only if the sample was taken in RUN.
  logic signed [ERR_W-1:0] s1_err_q;
  logic                    s1_vld_q, s1_run_q;
  logic signed [SUM_W-1:0] sum_d, s2_sum_q;
  logic                    s2_vld_q;
  logic        [OUT_W-1:0] i_term;
  logic        [OUT_W-1:0] drv_d, drv_q;
  logic                    sat_d, sat_q, vld_q;

  assign i_term = integ_q[INT_W-2 -: OUT_W];

  always_comb begin
    sum_d = SUM_W'(s1_err_q) + $signed(SUM_W'(i_term))
          + (s1_run_q ? SUM_W'(d_term) : SUM_W'(0));
  end

  always_comb begin
    drv_d = drv_q;
    sat_d = sat_q;
    if (s2_vld_q) begin
      if (s2_sum_q[SUM_W-1]) begin
        drv_d = '0;
        sat_d = 1'b0;
      end else if (s2_sum_q[OUT_W]) begin
        drv_d = '1;
        sat_d = 1'b1;
      end else begin
        drv_d = s2_sum_q[OUT_W-1:0];
        sat_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_err_q <= '0;
      s1_vld_q <= 1'b0;
      s1_run_q <= 1'b0;
      s2_sum_q <= '0;
      s2_vld_q <= 1'b0;
      drv_q    <= '0;
      sat_q    <= 1'b0;
      vld_q    <= 1'b0;
    end else begin
      s1_vld_q <= err_vld;
      if (err_vld) begin
        s1_err_q <= error;
        s1_run_q <= (state_q == S_RUN);
      end
      s2_vld_q <= s1_vld_q;
      if (s1_vld_q) s2_sum_q <= sum_d;
      drv_q <= drv_d;
      sat_q <= sat_d;
      vld_q <= s2_vld_q;
    end
  end

  assign drv_mag = drv_q;
  assign drv_vld = vld_q;
  assign sat_hi  = sat_q;

endmodule

// File: tb/tb_pid_ctrl_param.sv
// Directed bench for pid_ctrl_param with a behavioural model feeding a scoreboard.
// The DUT tick window is shortened to 4 bits (tick every 16 clocks).
module tb_pid_ctrl_param;

  localparam int ERR_W       = 13;
  localparam int OUT_W       = 12;
  localparam int INT_W       = 18;
  localparam int D_DEPTH     = 3;
  localparam int KD_SHIFT    = 1;
  localparam int TICK_W      = 4;
  localparam int TICK_PERIOD = 1 << TICK_W;
  localparam int INT_MAX     = (1 << (INT_W - 1)) - 1;
  localparam int OUT_MAX     = (1 << OUT_W) - 1;
  localparam int M_IDLE = 0, M_WARM = 1, M_RUN = 2;

  logic                    clk = 1'b0;
  logic                    rst_n = 1'b0;
  logic signed [ERR_W-1:0] error = '0;
  logic                    err_vld = 1'b0;
  logic                    not_pedaling = 1'b1;
  logic        [OUT_W-1:0] drv_mag;
  logic                    drv_vld;
  logic                    sat_hi;

  always #5 clk = ~clk;

  pid_ctrl_param #(
    .ERR_W   (ERR_W),
    .OUT_W   (OUT_W),
    .INT_W   (INT_W),
    .D_DEPTH (D_DEPTH),
    .KD_SHIFT(KD_SHIFT),
    .TICK_W  (TICK_W)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .error       (error),
    .err_vld     (err_vld),
    .not_pedaling(not_pedaling),
    .drv_mag     (drv_mag),
    .drv_vld     (drv_vld),
    .sat_hi      (sat_hi)
  );

  typedef struct {
    int drv;
    bit sat;
    int due;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   failures = 0;
  int   edge_cnt = 0;
  int   last_drv = 0;
  bit   last_sat = 1'b0;

  int m_cnt, m_state, m_warm, m_integ, m_d;
  int m_hist [D_DEPTH];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    m_integ = 0;
    m_d     = 0;
    for (int k = 0; k < D_DEPTH; k++) m_hist[k] = 0;
  endtask

  task automatic model_reset();
    m_cnt   = 0;
    m_state = M_IDLE;
    m_warm  = 0;
    model_clear();
  endtask

  task automatic monitor();
    bit   exp_vld;
    exp_t e;
    exp_vld = (sb.size() > 0) && (sb[0].due == edge_cnt);
    check("drv_vld", drv_vld, exp_vld);
    if (exp_vld) begin
      e = sb.pop_front();
      last_drv = e.drv;
      last_sat = e.sat;
    end
    check("drv_mag", drv_mag, last_drv);
    check("sat_hi", sat_hi, last_sat);
  endtask

  // One clock: drive at the falling edge, predict, clock, then compare.
  task automatic step(input bit np, input bit vld, input int e);
    bit   tick, pre_run;
    int   diff, it, dd, s;
    exp_t x;
    not_pedaling = np;
    err_vld      = vld;
    error        = ERR_W'(e);
    if (rst_n) begin
      tick    = (m_cnt % TICK_PERIOD) == (TICK_PERIOD - 1);
      pre_run = (m_state == M_RUN);
      if (np) begin
        m_state = M_IDLE;
        m_warm  = 0;
        model_clear();
      end else if (m_state == M_IDLE) begin
        model_clear();
        m_state = M_WARM;
        m_warm  = 0;
      end else begin
        if (tick && vld) begin
          m_integ += e;
          if (m_integ < 0) m_integ = 0;
          if (m_integ > INT_MAX) m_integ = INT_MAX;
          diff = e - m_hist[D_DEPTH-1];
          if (diff > 255) diff = 255;
          if (diff < -256) diff = -256;
          m_d = diff * (1 << KD_SHIFT);
          for (int k = D_DEPTH - 1; k > 0; k--) m_hist[k] = m_hist[k-1];
          m_hist[0] = e;
        end
        if (m_state == M_WARM && tick) begin
          if (m_warm == D_DEPTH - 1) m_state = M_RUN;
          else m_warm++;
        end
      end
      m_cnt++;
      if (vld) begin
        it = (m_integ >> (INT_W - 1 - OUT_W)) % (1 << OUT_W);
        dd = pre_run ? m_d : 0;
        s  = e + it + dd;
        x.due = edge_cnt + 3;
        if (s < 0) begin
          x.drv = 0;
          x.sat = 1'b0;
        end else if (s > OUT_MAX) begin
          x.drv = OUT_MAX;
          x.sat = 1'b1;
        end else begin
          x.drv = s;
          x.sat = 1'b0;
        end
        sb.push_back(x);
      end
    end
    @(posedge clk);
    edge_cnt++;
    @(negedge clk);
    monitor();
  endtask

  task automatic idle_steps(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 0);
  endtask

  task automatic wait_tick(input bit vld_all, input int e);
    int guard = 0;
    while (((m_cnt % TICK_PERIOD) != (TICK_PERIOD - 1)) && (guard < 2 * TICK_PERIOD)) begin
      step(1'b0, vld_all, e);
      guard++;
    end
  endtask

  task automatic tick_hold(input bit vld_all, input int e, input int n);
    for (int t = 0; t < n; t++) begin
      wait_tick(vld_all, e);
      step(1'b0, 1'b1, e);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    model_reset();
    @(negedge clk);
    step(1'b1, 1'b0, 0);
    step(1'b1, 1'b0, 0);
    check("reset_drv", drv_mag, 0);
    check("reset_sat", sat_hi, 0);

    rst_n = 1'b1;
    step(1'b1, 1'b1, 50);
    repeat (3) step(1'b1, 1'b0, 0);
    check("idle_p_only", drv_mag, 50);

    step(1'b0, 1'b0, 0);
    tick_hold(1'b0, 100, 1);
    idle_steps(2);
    check("warm_first_tick", drv_mag, 103);

    tick_hold(1'b1, -200, 4);
    idle_steps(2);
    check("neg_floor", drv_mag, 0);

    tick_hold(1'b1, 4095, 40);
    idle_steps(2);
    check("full_scale", drv_mag, OUT_MAX);
    check("full_scale_sat", sat_hi, 1);

    wait_tick(1'b1, 4095);
    step(1'b1, 1'b1, 4095);
    idle_steps(2);
    check("clear_on_tick_drv", drv_mag, 4095);
    check("clear_on_tick_sat", sat_hi, 0);

    step(1'b0, 1'b0, 0);
    tick_hold(1'b0, 300, 1);
    idle_steps(2);
    check("warm_d_gated", drv_mag, 309);
    tick_hold(1'b0, 300, 3);

    step(1'b1, 1'b0, 0);
    step(1'b0, 1'b0, 0);
    tick_hold(1'b0, 0, D_DEPTH + 1);
    tick_hold(1'b0, 600, 1);
    idle_steps(2);
    check("run_step_600", drv_mag, 1128);
    tick_hold(1'b1, 600, 1);

    step(1'b0, 1'b1, 600);
    step(1'b0, 1'b1, 600);
    rst_n = 1'b0;
    #1;
    check("async_rst_drv", drv_mag, 0);
    check("async_rst_vld", drv_vld, 0);
    check("async_rst_sat", sat_hi, 0);
    sb.delete();
    model_reset();
    last_drv = 0;
    last_sat = 1'b0;
    idle_steps(2);
    @(negedge clk);
    rst_n = 1'b1;
    idle_steps(4);
    step(1'b0, 1'b1, 77);
    idle_steps(3);
    check("post_reset_sample", drv_mag, 77);
    check("sb_drained", sb.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
